// File: rtl/fetch_sequencer.sv
// Instruction fetch front-end: PC, imem request/ready handshake, one instruction
// in flight to decode, next-PC on commit. Optional macro: FETCH_MISALIGN_EXC_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ack,
  input  logic        isJmp,
  input  logic        isJal,
  input  logic        isJr,
  input  logic [2:0]  branch,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        fetch_exc
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t      state, next_state;
  logic        req_q;
  logic        accept, commit;
  logic        taken, misalign;
  logic [31:0] next_pc;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (accept)    next_state = EXEC;
      EXEC:    if (instr_ack) next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = req_q;
    imem_addr   = pc;
    pc_plus4    = pc + 32'd4;
    instr_valid = (state == EXEC);
    accept      = (state == FETCH) && req_q && imem_rdy;
    commit      = (state == EXEC) && instr_ack;
  end

  always_comb begin
    taken = 1'b0;
    case (branch)
      3'd1:    taken = (rs_val == rt_val);
      3'd2:    taken = (rs_val != rt_val);
      3'd3:    taken = ($signed(rs_val) >= 0);
      3'd4:    taken = ($signed(rs_val) >  0);
      3'd5:    taken = ($signed(rs_val) <= 0);
      3'd6:    taken = ($signed(rs_val) <  0);
      default: taken = 1'b0;
    endcase
  end

`ifdef FETCH_MISALIGN_EXC_EN
  logic exc_q;
  assign misalign  = isJr && (rs_val[1:0] != 2'b00);
  assign fetch_exc = exc_q;

  always_ff @(posedge clk) begin
    if (rst)         exc_q <= 1'b0;
    else if (commit) exc_q <= misalign;
  end
`else
  assign misalign  = 1'b0;
  assign fetch_exc = 1'b0;
`endif

  always_comb begin
    next_pc = pc_plus4;
    if (misalign)           next_pc = EXC_VECTOR;
    else if (isJr)          next_pc = rs_val;
    else if (isJmp || isJal) next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (taken)         next_pc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  end

  // The request is registered so it drops on the reset edge and first rises
  // the cycle after rst deasserts; FETCH only accepts rdy while requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      instr <= '0;
      req_q <= 1'b0;
    end else begin
      req_q <= (next_state == FETCH);
      if (accept) instr <= imem_rdata;
      if (commit) pc    <= next_pc;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed cases plus randomized
// instruction streams checked against a transaction-level next-PC model.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ack;
  logic        isJmp, isJal, isJr;
  logic [2:0]  branch;
  logic [31:0] rs_val, rt_val;
  logic        fetch_exc;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  bit          exp_exc;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC  (RESET_PC),
    .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdy   (imem_rdy),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr_ack  (instr_ack),
    .isJmp      (isJmp),
    .isJal      (isJal),
    .isJr       (isJr),
    .branch     (branch),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .fetch_exc  (fetch_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC straight from the ISA rules, using integer arithmetic.
  function automatic logic [31:0] model_next(
    input logic [31:0] cur, input logic [31:0] word,
    input bit jr, input bit jmp, input bit jal, input logic [2:0] br,
    input logic [31:0] rs, input logic [31:0] rt, output bit exc);
    logic [31:0] seq;
    int          srs, off;
    bit          tk;
    seq = cur + 32'd4;
    srs = int'($signed(rs));
    off = int'($signed(word[15:0])) * 4;
    exc = 1'b0;
    case (br)
      3'd1:    tk = (rs == rt);
      3'd2:    tk = (rs != rt);
      3'd3:    tk = (srs >= 0);
      3'd4:    tk = (srs > 0);
      3'd5:    tk = (srs <= 0);
      3'd6:    tk = (srs < 0);
      default: tk = 1'b0;
    endcase
    if (jr) begin
`ifdef FETCH_MISALIGN_EXC_EN
      if (rs % 4 != 0) begin
        exc = 1'b1;
        return EXC_VECTOR;
      end
`endif
      return rs;
    end
    if (jmp || jal) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (tk) return seq + 32'(off);
    return seq;
  endfunction

  // One full fetch/execute transaction with optional rdy and ack stalls.
  task automatic run_instr(input logic [31:0] word, input int rdy_wait, input int ack_wait,
                           input bit jr, input bit jmp, input bit jal, input logic [2:0] br,
                           input logic [31:0] rs, input logic [31:0] rt);
    bit e;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    chk("fetch_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < rdy_wait; i++) begin
      imem_rdy = 1'b0; imem_rdata = $urandom; instr_ack = 1'b1;
      step();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    instr_ack = 1'b0; imem_rdy = 1'b1; imem_rdata = word;
    step();
    imem_rdy = 1'b0;
    chk("exec_valid", 32'(instr_valid), 32'd1);
    chk("exec_instr", instr, word);
    chk("exec_pc", pc, exp_pc);
    chk("exec_pc4", pc_plus4, exp_pc + 32'd4);
    chk("exec_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < ack_wait; i++) begin
      imem_rdy = 1'b1; imem_rdata = ~word;
      isJr = $urandom_range(1); isJmp = $urandom_range(1); branch = 3'($urandom);
      rs_val = $urandom;
      step();
      chk("hold_instr", instr, word);
      chk("hold_pc", pc, exp_pc);
      chk("hold_valid", 32'(instr_valid), 32'd1);
    end
    imem_rdy = 1'b0;
    isJr = jr; isJmp = jmp; isJal = jal; branch = br; rs_val = rs; rt_val = rt;
    instr_ack = 1'b1;
    exp_pc = model_next(exp_pc, word, jr, jmp, jal, br, rs, rt, e);
    exp_exc = e;
    step();
    instr_ack = 1'b0; isJr = 1'b0; isJmp = 1'b0; isJal = 1'b0; branch = 3'd0;
    chk("commit_valid", 32'(instr_valid), 32'd0);
    chk("commit_pc", pc, exp_pc);
    chk("commit_exc", 32'(fetch_exc), 32'(exp_exc));
  endtask

  task automatic jr_to(input logic [31:0] target);
    run_instr($urandom, 0, 0, 1'b1, 1'b0, 1'b0, 3'd0, target, 32'd0);
  endtask

  initial begin
    bit          jr, jm, jl;
    logic [2:0]  br;
    logic [31:0] rs, rt;
    rst = 1'b1; imem_rdy = 1'b0; imem_rdata = '0; instr_ack = 1'b0;
    isJmp = 1'b0; isJal = 1'b0; isJr = 1'b0; branch = 3'd0; rs_val = '0; rt_val = '0;
    exp_pc = RESET_PC; exp_exc = 1'b0;
    step(); step();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_exc", 32'(fetch_exc), 32'd0);
    rst = 1'b0;
    step();

    // Back-to-back sequential fetches.
    for (int k = 0; k < 3; k++) begin
      chk("seq_addr", imem_addr, 32'h0040_0000 + 32'(4 * k));
      run_instr($urandom, 0, 0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
    end
    // rdy stall of 3 cycles with ignored acks.
    run_instr(32'hDEAD_BEEF, 3, 2, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
    chk("stall_pc", pc, 32'h0040_0010);

    jr_to(32'h0040_0010);
    run_instr(32'h1085_FFFE, 0, 0, 1'b0, 1'b0, 1'b0, 3'd1, 32'd5, 32'd5);
    chk("beq_taken", pc, 32'h0040_000C);
    jr_to(32'h0040_0010);
    run_instr(32'h1085_FFFE, 0, 0, 1'b0, 1'b0, 1'b0, 3'd1, 32'd5, 32'd6);
    chk("beq_not", pc, 32'h0040_0014);
    jr_to(32'h0040_0000);
    run_instr(32'h0400_0003, 0, 0, 1'b0, 1'b0, 1'b0, 3'd6, 32'hFFFF_FFFF, '0);
    chk("bltz_taken", pc, 32'h0040_0010);
    jr_to(32'h0040_0000);
    run_instr(32'h1C00_0003, 0, 0, 1'b0, 1'b0, 1'b0, 3'd4, 32'd0, '0);
    chk("bgtz_zero", pc, 32'h0040_0004);
    jr_to(32'h0040_0020);
    run_instr(32'h0C10_0040, 1, 1, 1'b0, 1'b0, 1'b1, 3'd0, '0, '0);
    chk("jal_target", pc, 32'h0040_0100);
    run_instr(32'h0800_0001, 0, 0, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0040_0200, 32'h0040_0200);
    chk("jr_wins", pc, 32'h0040_0200);
    jr_to(32'h0040_0202);
`ifdef FETCH_MISALIGN_EXC_EN
    chk("misalign_pc", pc, EXC_VECTOR);
    chk("misalign_exc", 32'(fetch_exc), 32'd1);
`else
    chk("misalign_pc", pc, 32'h0040_0202);
    chk("misalign_exc", 32'(fetch_exc), 32'd0);
`endif
    jr_to(32'h0040_0300);
    chk("exc_clear", 32'(fetch_exc), 32'd0);

    // Reset in FETCH with rdy high in the same cycle.
    rst = 1'b1; imem_rdy = 1'b1; imem_rdata = $urandom;
    step();
    chk("rstf_pc", pc, RESET_PC);
    chk("rstf_valid", 32'(instr_valid), 32'd0);
    chk("rstf_req", 32'(imem_req), 32'd0);
    rst = 1'b0; imem_rdy = 1'b0;
    step();
    chk("rstf_req_back", 32'(imem_req), 32'd1);
    chk("rstf_addr", imem_addr, RESET_PC);
    exp_pc = RESET_PC; exp_exc = 1'b0;
    jr_to(32'h0050_0000);

    // Reset in EXEC together with ack.
    imem_rdy = 1'b1; imem_rdata = $urandom;
    step();
    imem_rdy = 1'b0; rst = 1'b1; instr_ack = 1'b1; isJr = 1'b1; rs_val = 32'h1234_5678;
    step();
    chk("rste_pc", pc, RESET_PC);
    chk("rste_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0; instr_ack = 1'b0; isJr = 1'b0;
    step();
    exp_pc = RESET_PC; exp_exc = 1'b0;

    for (int n = 0; n < 200; n++) begin
      jr = ($urandom_range(7) == 0);
      jm = ($urandom_range(7) == 0);
      jl = ($urandom_range(7) == 0);
      br = 3'($urandom);
      rt = $urandom;
      case ($urandom_range(3))
        0:       rs = rt;
        1:       rs = 32'd0;
        2:       rs = 32'($signed(4'($urandom)));
        default: rs = $urandom;
      endcase
      run_instr($urandom, $urandom_range(3), $urandom_range(3), jr, jm, jl, br, rs, rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end stage that sits upstream of the instruction decoder/control unit and feeds it instructions.
- Holds the PC and runs a request/ready handshake with instruction memory.
- Presents one instruction at a time to decode/execute and waits for commit.
- On commit, computes the next PC from the decoded jump/branch controls fed back by the control unit and datapath.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, redirect target for a misaligned jump-register target (used only when the optional feature is compiled in).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address, equal to pc.
- imem_rdy  in  1  memory ready; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction delivered to decode.
- instr_valid  out  1  instr/pc are valid and awaiting commit.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4; used as the link value for JAL.
- instr_ack  in  1  execute has committed the current instruction this cycle.
- isJmp  in  1  decoded J.
- isJal  in  1  decoded JAL.
- isJr  in  1  decoded JR.
- branch  in  3  branch type: 0 none, 1 BEQ, 2 BNE, 3 BGEZ, 4 BGTZ, 5 BLEZ, 6 BLTZ, 7 none.
- rs_val  in  32  register file rs read data.
- rt_val  in  32  register file rt read data.
- fetch_exc  out  1  misaligned JR target flag (optional feature only).

Behaviour:
- Clocking/reset: single clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_exc=0, state=FETCH. rst overrides every other input in the same edge.
- pc_plus4 = pc + 32'd4, combinational, modulo 2^32.
- imem_addr = pc at all times.

State machine:
- FETCH:
  - imem_req=1, addr held stable.
  - imem_rdy=1: latch instr<=imem_rdata, instr_valid<=1, go EXEC.
  - imem_rdy=0: stay in FETCH, request held.
- EXEC:
  - imem_req=0, instr_valid=1, instr and pc held stable.
  - instr_ack=1: pc<=next_pc, instr_valid<=0, go FETCH.
  - instr_ack=0: hold.

Rules:
- Latency: earliest imem_rdy is the first FETCH cycle, so instr_valid rises one cycle after that rdy. Minimum 2 cycles per instruction.
- imem_rdy is ignored outside FETCH; instr_ack is ignored outside EXEC.
- Control inputs (isJmp, isJal, isJr, branch, rs_val, rt_val) are sampled only in the EXEC cycle where instr_ack=1.

next_pc selection, highest priority first:
1. isJr: rs_val.
2. isJmp or isJal: {pc_plus4[31:28], instr[25:0], 2'b00}.
3. branch taken: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), 32-bit wraparound.
4. Otherwise: pc_plus4.

Branch taken conditions (rs_val/rt_val compared as signed 32-bit):
- 1: rs_val == rt_val.
- 2: rs_val != rt_val.
- 3: rs_val >= 0.
- 4: rs_val > 0.
- 5: rs_val <= 0.
- 6: rs_val < 0.
- 0 or 7: never taken.

No delay slot. Multiple simultaneous control inputs resolve by the priority above; there is no error.

Reset mid-operation:
- rst during a FETCH wait: imem_req drops in the next cycle; the late rdy is ignored since the state is re-entered cleanly. The first new request (addr=RESET_PC) is issued the cycle after rst deasserts.
- rst during EXEC with ack: reset wins, pc=RESET_PC.

Optional Feature:
- Macro: FETCH_MISALIGN_EXC_EN.
- Defined:
  - On commit with isJr=1 and rs_val[1:0]!=0: pc<=EXC_VECTOR and fetch_exc<=1.
  - fetch_exc stays 1 until the next commit or rst.
  - Otherwise fetch_exc<=0 at each commit.
- Undefined:
  - fetch_exc port tied 0.
  - JR target is used unmodified, including low bits.

Test Plan:
- Reset then imem_rdy=1 every cycle, instr_ack=1 whenever instr_valid → imem_addr sequence 0x00400000, 0x00400004, 0x00400008; instr_valid high every second cycle.
- imem_rdy held low 3 cycles in FETCH → imem_req and imem_addr stable for 4 cycles; instr latched only on the rdy cycle; ack while instr_valid=0 has no effect.
- pc=0x00400010, instr imm=0xFFFE, branch=1, rs_val=rt_val=5, ack → next pc=0x0040000C. Same with rt_val=6 → 0x00400014.
- branch=6, rs_val=0xFFFFFFFF, imm=0x0003 at pc=0x00400000 → 0x00400010. branch=4 with rs_val=0 → 0x00400004.
- isJal=1, instr[25:0]=0x0100040 at pc=0x00400020 → pc_plus4=0x00400024 at ack, next pc=0x00400100. isJr=1 with isJmp=1, rs_val=0x00400200 → 0x00400200 (JR wins).
- FETCH_MISALIGN_EXC_EN: isJr, rs_val=0x00400202 → pc=0x80000180, fetch_exc=1. rst asserted mid-FETCH with imem_rdy=1 in the same cycle → pc=RESET_PC, instr_valid=0, imem_req=0 for that cycle.
